gshare_branch_predictor: RTL
============================

GSHARE_BRANCH_PREDICTOR -- requirements
Module: gshare_branch_predictor

Interface
REQ-001 SHALL provide parameter BHT_BITS, default 12: pattern-table index width, giving 2**BHT_BITS 2-bit counters.
REQ-002 SHALL provide parameter GHR_BITS, default 8: global history length; legal range 1..BHT_BITS.
REQ-003 SHALL provide parameter BTB_BITS, default 6: BTB index width, giving 2**BTB_BITS entries.
REQ-004 SHALL provide parameter TAG_BITS, default 8: BTB tag width; BTB_BITS+TAG_BITS+2 <= 32.
REQ-005 SHALL have one clock; reset is asynchronous and active-low; ports: CLK in 1, rising-edge clock; RESETN in 1, async active-low reset.
REQ-006 SHALL have port PCF in 32: fetch PC, word-aligned.
REQ-007 SHALL have port FetchValidF in 1: fetch stage advances this cycle.
REQ-008 SHALL have port PredictedTakenF out 1: predicted direction.
REQ-009 SHALL have port PredictedBTAF out 32: predicted next PC.
REQ-010 SHALL have port BTBHitF out 1: PCF hits a valid BTB entry.
REQ-011 SHALL have port GHRF out GHR_BITS: history checkpoint used for this fetch, carried down the pipeline.
REQ-012 SHALL have port ReadyF out 1: table initialisation complete.
REQ-013 SHALL have ports PCE in 32, IsBranchE in 1, ActualTakenE in 1, ActualBTAE in 32, GHRE in GHR_BITS (checkpoint of the resolving branch), and MispredictE in 1 (direction or target mispredicted).

Function
REQ-014 SHALL compute IndexF = PCF[BHT_BITS+1:2] XOR zero-extended GHR, and IndexE = PCE[BHT_BITS+1:2] XOR zero-extended GHRE.
REQ-015 SHALL index the BTB with PC[BTB_BITS+1:2] and tag with PC[BTB_BITS+TAG_BITS+1:BTB_BITS+2]; hit = valid AND tag match.
REQ-016 SHALL drive, combinationally while READY: BTBHitF = hit; PredictedTakenF = hit AND BHT[IndexF][1]; PredictedBTAF = BTB target if PredictedTakenF, else PCF+4 (mod 2**32); GHRF = current GHR.
REQ-017 SHALL, while in INIT, force PredictedTakenF=0, BTBHitF=0, PredictedBTAF=PCF+4, ReadyF=0.
REQ-018 SHALL, on MispredictE=1 with IsBranchE=1 in READY, load GHR <= {GHRE[GHR_BITS-2:0], ActualTakenE}; for GHR_BITS=1, GHR <= ActualTakenE.
REQ-019 SHALL otherwise, on FetchValidF=1 AND BTBHitF=1 in READY, shift GHR <= {GHR[GHR_BITS-2:0], PredictedTakenF}; if neither condition holds, GHR holds.
REQ-020 SHALL give the mispredict repair priority over the fetch shift when both occur in the same cycle.
REQ-021 SHALL, on IsBranchE=1 in READY, update BHT[IndexE] as a saturating counter: increment if ActualTakenE (hold at 11), decrement otherwise (hold at 00).
REQ-022 SHALL, on IsBranchE=1 AND ActualTakenE=1 in READY, write the BTB entry: valid=1, tag from PCE, target=ActualBTAE; a not-taken branch SHALL leave the BTB unchanged.
REQ-023 SHALL return the pre-write value for a same-cycle fetch read and execute write to the same BHT or BTB entry.
REQ-024 SHALL ignore all execute-stage inputs and FetchValidF while in INIT.
REQ-025 SHALL implement a two-state FSM, INIT and READY. INIT writes BHT[InitCnt]=01 each cycle with InitCnt incrementing from 0. After writing entry 2**BHT_BITS-1, the FSM moves to READY, so ReadyF rises exactly 2**BHT_BITS cycles after RESETN deasserts. READY is held until reset.

Reset
REQ-026 SHALL, asynchronously on RESETN=0, enter INIT, clear InitCnt, GHR and all BTB valid bits; BHT and BTB target/tag storage need no reset.
REQ-027 SHALL, on reset asserted mid-operation (including mid-INIT), restart INIT from entry 0 after deassertion.
REQ-028 SHALL hold ReadyF=0, PredictedTakenF=0, BTBHitF=0 and GHRF=0 during reset.

Verification
REQ-029 Reset, then count cycles -> ReadyF=0 for exactly 4096 cycles after RESETN rises, then 1; every BHT entry reads 01.
REQ-030 In READY, PCF=0x100 with empty BTB -> BTBHitF=0, PredictedTakenF=0, PredictedBTAF=0x104, GHR unchanged by FetchValidF=1.
REQ-031 Resolve PCE=0x100, GHRE=0, taken, ActualBTAE=0x200 twice, MispredictE=1 the first time -> counter 01->10->11, BTB hit; then PCF=0x100 with GHR=0 gives PredictedTakenF=1, PredictedBTAF=0x200.
REQ-032 Resolve the same branch not-taken three times -> counter saturates at 00, fourth not-taken keeps 00; BTB entry stays valid with target 0x200.
REQ-033 GHR=0x5A; same cycle MispredictE=1, GHRE=0x33, ActualTakenE=1, and FetchValidF=1 with a BTB hit -> next GHR=0x67, fetch shift discarded.
REQ-034 Assert RESETN=0 for one cycle at InitCnt=100 with GHR and BTB populated -> outputs drop immediately, BTB hits cease, INIT restarts and takes a full 4096 cycles.

Source files
------------

// File: rtl/gshare_branch_predictor.sv
// Gshare direction predictor with a direct-mapped BTB and global history checkpointing.
// After reset, the counter table is walked to weakly-not-taken before predictions are enabled.
module gshare_branch_predictor #(
    parameter int unsigned BHT_BITS = 12,
    parameter int unsigned GHR_BITS = 8,
    parameter int unsigned BTB_BITS = 6,
    parameter int unsigned TAG_BITS = 8
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic [31:0]         PCF,
    input  logic                FetchValidF,
    output logic                PredictedTakenF,
    output logic [31:0]         PredictedBTAF,
    output logic                BTBHitF,
    output logic [GHR_BITS-1:0] GHRF,
    output logic                ReadyF,
    input  logic [31:0]         PCE,
    input  logic                IsBranchE,
    input  logic                ActualTakenE,
    input  logic [31:0]         ActualBTAE,
    input  logic [GHR_BITS-1:0] GHRE,
    input  logic                MispredictE
);

    localparam int unsigned BHT_ENTRIES = 2 ** BHT_BITS;
    localparam int unsigned BTB_ENTRIES = 2 ** BTB_BITS;

    typedef enum logic {
        S_INIT,
        S_READY
    } state_e;

    state_e                state_q, state_d;
    logic [BHT_BITS-1:0]   init_cnt_q, init_cnt_d;
    logic [GHR_BITS-1:0]   ghr_q, ghr_d;

    logic [1:0]            bht_q [BHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] btb_valid_q;
    logic [TAG_BITS-1:0]   btb_tag_q [BTB_ENTRIES];
    logic [31:0]           btb_target_q [BTB_ENTRIES];

    logic                  ready;
    logic [BHT_BITS-1:0]   idx_f, idx_e;
    logic [BTB_BITS-1:0]   btb_idx_f, btb_idx_e;
    logic [TAG_BITS-1:0]   btb_tag_f, btb_tag_e;
    logic [1:0]            ctr_e;
    logic                  btb_hit_f, pred_taken_f;
    logic                  bht_we, btb_we;
    logic [BHT_BITS-1:0]   bht_waddr;
    logic [1:0]            bht_wdata;
    logic                  unused_pc_bits;

    assign ready     = (state_q == S_READY);
    assign idx_f     = PCF[BHT_BITS+1:2] ^ BHT_BITS'(ghr_q);
    assign idx_e     = PCE[BHT_BITS+1:2] ^ BHT_BITS'(GHRE);
    assign btb_idx_f = PCF[BTB_BITS+1:2];
    assign btb_idx_e = PCE[BTB_BITS+1:2];
    assign btb_tag_f = PCF[BTB_BITS+TAG_BITS+1:BTB_BITS+2];
    assign btb_tag_e = PCE[BTB_BITS+TAG_BITS+1:BTB_BITS+2];
    assign ctr_e     = bht_q[idx_e];
    assign unused_pc_bits = ^{PCF, PCE};

    // Fetch-side lookup; table reads see pre-write contents of any same-cycle update
    assign btb_hit_f    = ready & btb_valid_q[btb_idx_f] & (btb_tag_q[btb_idx_f] == btb_tag_f);
    assign pred_taken_f = btb_hit_f & bht_q[idx_f][1];

    assign BTBHitF         = btb_hit_f;
    assign PredictedTakenF = pred_taken_f;
    assign PredictedBTAF   = pred_taken_f ? btb_target_q[btb_idx_f] : (PCF + 32'd4);
    assign GHRF            = ghr_q;
    assign ReadyF          = ready;

    assign btb_we = ready & IsBranchE & ActualTakenE;

    // Counter table write port: init sweep, or saturating update from execute
    always_comb begin
        bht_we    = 1'b0;
        bht_waddr = idx_e;
        bht_wdata = ctr_e;
        if (!ready) begin
            bht_we    = 1'b1;
            bht_waddr = init_cnt_q;
            bht_wdata = 2'b01;
        end else if (IsBranchE) begin
            bht_we = 1'b1;
            if (ActualTakenE) begin
                bht_wdata = (ctr_e == 2'b11) ? 2'b11 : ctr_e + 2'd1;
            end else begin
                bht_wdata = (ctr_e == 2'b00) ? 2'b00 : ctr_e - 2'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        ghr_d      = ghr_q;
        case (state_q)
            S_INIT: begin
                init_cnt_d = init_cnt_q + BHT_BITS'(1);
                if (init_cnt_q == '1) begin
                    state_d = S_READY;
                end
            end
            S_READY: begin
                // Repair from the resolving branch's checkpoint wins over speculative shift
                if (MispredictE && IsBranchE) begin
                    ghr_d = GHR_BITS'({GHRE, ActualTakenE});
                end else if (FetchValidF && btb_hit_f) begin
                    ghr_d = GHR_BITS'({ghr_q, pred_taken_f});
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q     <= S_INIT;
            init_cnt_q  <= '0;
            ghr_q       <= '0;
            btb_valid_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            ghr_q      <= ghr_d;
            if (btb_we) begin
                btb_valid_q[btb_idx_e] <= 1'b1;
            end
        end
    end

    // Table payload storage carries no reset; validity lives in btb_valid_q
    always_ff @(posedge CLK) begin
        if (bht_we) begin
            bht_q[bht_waddr] <= bht_wdata;
        end
        if (btb_we) begin
            btb_tag_q[btb_idx_e]    <= btb_tag_e;
            btb_target_q[btb_idx_e] <= ActualBTAE;
        end
    end

endmodule
